// File: rtl/calc_pkg.sv
// Shared types and default sizing for the calculator request path and its button inputs.
package calc_pkg;

    localparam int W_IN_DEF            = 8;
    localparam int W_OUT_DEF           = 24;
    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int ACK_TIMEOUT_DEF     = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, stability counter and a one-cycle press pulse.
// A button already held when reset is released is ignored until it has been seen released.
module btn_debounce
    import calc_pkg::*;
#(
    parameter int CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES);

    logic          sync1_q, sync2_q, last_q;
    logic          level_q, level_d;
    logic          armed_q, armed_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_s;

    always_comb begin
        stable_s = (cnt_q == CNT_MAX) && (sync2_q == last_q);
        cnt_d    = cnt_q;
        level_d  = level_q;
        armed_d  = armed_q;
        press_d  = 1'b0;
        if (sync2_q != last_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
        if (stable_s) begin
            level_d = sync2_q;
            armed_d = armed_q | ~sync2_q;
            press_d = sync2_q & ~level_q & armed_q;
        end else begin
            level_d = level_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            armed_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            last_q  <= sync2_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            armed_q <= armed_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/calc_request_ctrl.sv
// Start/busy initiator for the arithmetic unit: latches operands on a clean press,
// pulses start, waits for busy to rise and fall, and captures the result.
module calc_request_ctrl
    import calc_pkg::*;
#(
    parameter int W_IN            = W_IN_DEF,
    parameter int W_OUT           = W_OUT_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int ACK_TIMEOUT     = ACK_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_raw,
    input  logic [W_IN-1:0]  sw_a,
    input  logic [W_IN-1:0]  sw_b,
    output logic [W_IN-1:0]  a,
    output logic [W_IN-1:0]  b,
    output logic             start,
    input  logic             busy,
    input  logic [W_OUT-1:0] y,
    output logic [W_OUT-1:0] result,
    output logic             result_valid,
    output logic             err
);

    localparam int AW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [W_IN-1:0]   a_q, a_d, b_q, b_d;
    logic              start_q, start_d;
    logic [W_OUT-1:0]  result_q, result_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [AW-1:0]     ack_cnt_q, ack_cnt_d;
    logic              press_s;

    btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_raw),
        .press   (press_s)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        start_d   = 1'b0;
        result_d  = result_q;
        valid_d   = valid_q;
        err_d     = err_q;
        ack_cnt_d = ack_cnt_q;
        case (state_q)
            IDLE: begin
                if (press_s && !busy) begin
                    a_d     = sw_a;
                    b_d     = sw_b;
                    start_d = 1'b1;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                ack_cnt_d = '0;
                state_d   = WAIT_ACK;
            end
            WAIT_ACK: begin
                // busy is tested first so an ack on the final count still wins
                if (busy) begin
                    state_d = WAIT_DONE;
                end else if (ack_cnt_q == ACK_LAST) begin
                    err_d   = 1'b1;
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    ack_cnt_d = ack_cnt_q + AW'(1);
                end
            end
            WAIT_DONE: begin
                if (!busy) begin
                    result_d = y;
                    valid_d  = 1'b1;
                    err_d    = 1'b0;
                    state_d  = IDLE;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            start_q   <= 1'b0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            ack_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            start_q   <= start_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            ack_cnt_q <= ack_cnt_d;
        end
    end

    assign a            = a_q;
    assign b            = b_q;
    assign start        = start_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign err          = err_q;

endmodule

// File: tb/tb_calc_request_ctrl.sv
// Self-checking bench for calc_request_ctrl with a behavioural func model (busy after start, y=a*b).
module tb_calc_request_ctrl;

    localparam int W_IN  = 8;
    localparam int W_OUT = 24;
    localparam int DEB   = 4;
    localparam int ACK   = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             btn_raw = 1'b1;
    logic [W_IN-1:0]  sw_a = 8'h00;
    logic [W_IN-1:0]  sw_b = 8'h00;
    logic [W_IN-1:0]  a, b;
    logic             start;
    logic             busy = 1'b0;
    logic [W_OUT-1:0] y = 24'h000000;
    logic [W_OUT-1:0] result;
    logic             result_valid;
    logic             err;

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;
    logic prev_start = 1'b0;
    logic model_en = 1'b1;
    int busy_len = 5;
    int fcnt = 0;
    logic [W_OUT-1:0] exp_q[$];

    typedef struct {
        logic [7:0]  va;
        logic [7:0]  vb;
        logic [23:0] vy;
    } vec_t;
    vec_t vecs[6];

    calc_request_ctrl #(
        .W_IN(W_IN), .W_OUT(W_OUT), .DEBOUNCE_CYCLES(DEB), .ACK_TIMEOUT(ACK)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .sw_a(sw_a), .sw_b(sw_b),
        .a(a), .b(b), .start(start), .busy(busy), .y(y),
        .result(result), .result_valid(result_valid), .err(err)
    );

    always #5 clk = ~clk;

    // func model: busy rises one cycle after start is seen and stays high busy_len cycles
    always @(posedge clk) begin
        if (fcnt != 0) begin
            if (fcnt > busy_len) begin
                busy <= 1'b0;
                fcnt <= 0;
            end else begin
                busy <= 1'b1;
                if (fcnt == 1) y <= 24'(a) * 24'(b);
                fcnt <= fcnt + 1;
            end
        end else if (start && model_en) begin
            fcnt <= 1;
        end
    end

    always @(posedge clk) begin
        if (start) start_cnt <= start_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, expv);
        end
    endtask

    // start must never be high in two consecutive cycles
    always @(negedge clk) begin
        if (start) chk("start_one_cycle", 32'(prev_start), 32'd0);
        prev_start = start;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_start();
        int n = 0;
        while (start !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", 32'(start), 32'd1);
    endtask

    task automatic wait_busy(input logic lvl, input string nm);
        int n = 0;
        while (busy !== lvl && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(busy), 32'(lvl));
    endtask

    task automatic run_op(input logic [7:0] va, input logic [7:0] vb,
                          input logic [23:0] vy, input bit bounce);
        int s0;
        logic [23:0] e;
        sw_a = va;
        sw_b = vb;
        exp_q.push_back(vy);
        s0 = start_cnt;
        if (bounce) begin
            for (int i = 0; i < 10; i++) begin
                btn_raw = ~btn_raw;
                cyc(2);
            end
        end
        btn_raw = 1'b1;
        wait_start();
        chk("op_a", 32'(a), 32'(va));
        chk("op_b", 32'(b), 32'(vb));
        wait_busy(1'b1, "busy_rise");
        wait_busy(1'b0, "busy_fall");
        cyc(1);
        e = exp_q.pop_front();
        chk("op_result", 32'(result), 32'(e));
        chk("op_valid", 32'(result_valid), 32'd1);
        chk("op_err", 32'(err), 32'd0);
        btn_raw = 1'b0;
        cyc(18);
        chk("op_start_count", 32'(start_cnt - s0), 32'd1);
    endtask

    initial begin
        int s0;
        int n;
        vecs[0] = '{8'h0C, 8'h0A, 24'h000078};
        vecs[1] = '{8'hFF, 8'hFF, 24'h00FE01};
        vecs[2] = '{8'h00, 8'h55, 24'h000000};
        vecs[3] = '{8'h01, 8'h80, 24'h000080};
        vecs[4] = '{8'h10, 8'h10, 24'h000100};
        vecs[5] = '{8'hA5, 8'h3C, 24'h0026AC};

        // reset with the button held
        cyc(2);
        chk("rst_a", 32'(a), 32'd0);
        chk("rst_b", 32'(b), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        s0 = start_cnt;
        cyc(12);
        chk("held_btn_no_start", 32'(start_cnt - s0), 32'd0);
        btn_raw = 1'b0;
        cyc(12);
        chk("released_no_start", 32'(start_cnt - s0), 32'd0);

        for (int i = 0; i < 6; i++) run_op(vecs[i].va, vecs[i].vb, vecs[i].vy, 1'b0);

        // bouncing press yields exactly one start
        run_op(8'h03, 8'h07, 24'h000015, 1'b1);

        // second press while waiting for a long busy, switches changed mid-op
        busy_len = 40;
        sw_a = 8'h0C;
        sw_b = 8'h0A;
        exp_q.push_back(24'h000078);
        s0 = start_cnt;
        btn_raw = 1'b1;
        wait_start();
        cyc(1);
        btn_raw = 1'b0;
        cyc(14);
        btn_raw = 1'b1;
        sw_a = 8'hFF;
        cyc(16);
        chk("midop_a_held", 32'(a), 32'h0C);
        chk("midop_no_second_start", 32'(start_cnt - s0), 32'd1);
        wait_busy(1'b0, "long_busy_fall");
        cyc(1);
        chk("midop_result", 32'(result), 32'(exp_q.pop_front()));
        chk("midop_valid", 32'(result_valid), 32'd1);
        chk("midop_a_after", 32'(a), 32'h0C);
        btn_raw = 1'b0;
        cyc(18);
        chk("midop_total_starts", 32'(start_cnt - s0), 32'd1);
        busy_len = 5;

        // func never acknowledges: timeout sets err and clears result_valid
        model_en = 1'b0;
        sw_a = 8'h03;
        sw_b = 8'h04;
        btn_raw = 1'b1;
        wait_start();
        n = 0;
        while (err !== 1'b1 && n < 30) begin
            cyc(1);
            n++;
        end
        chk("timeout_cycles", 32'(n), 32'(ACK + 1));
        chk("timeout_valid", 32'(result_valid), 32'd0);
        btn_raw = 1'b0;
        cyc(18);
        model_en = 1'b1;
        run_op(8'h03, 8'h04, 24'h00000C, 1'b0);

        // reset while waiting for busy to fall; the later fall must not be captured
        sw_a = 8'h05;
        sw_b = 8'h06;
        s0 = start_cnt;
        btn_raw = 1'b1;
        wait_start();
        wait_busy(1'b1, "rst6_busy_rise");
        cyc(2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("rst6_result", 32'(result), 32'd0);
        chk("rst6_valid", 32'(result_valid), 32'd0);
        chk("rst6_a", 32'(a), 32'd0);
        wait_busy(1'b0, "rst6_busy_fall");
        cyc(2);
        chk("rst6_no_capture", 32'(result), 32'd0);
        chk("rst6_no_valid", 32'(result_valid), 32'd0);
        btn_raw = 1'b0;
        cyc(18);
        chk("rst6_start_count", 32'(start_cnt - s0), 32'd1);
        run_op(8'h07, 8'h09, 24'h00003F, 1'b0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
